// File: rtl/conv3x3_kernel_pipe_pkg.sv
// Shared ISP definitions for the 3x3 convolution kernel: mode encodings,
// default coefficient set, accumulator sizing and the pixel clamp helpers.
package conv3x3_kernel_pipe_pkg;

    localparam logic [1:0] MODE_CONV     = 2'b00;
    localparam logic [1:0] MODE_BYPASS   = 2'b01;
    localparam logic [1:0] MODE_ABS      = 2'b10;
    localparam logic [1:0] MODE_CONV_ALT = 2'b11;

    localparam int NTAPS = 9;

    // Power-up mask: corners -1, edges +2, centre +4 (sums to 8 -> unity gain at SHIFT=3)
    function automatic int default_coef(input int idx);
        case (idx)
            4:          return 4;
            1, 3, 5, 7: return 2;
            default:    return -1;
        endcase
    endfunction

    // Nine products of DW+CW+1 bits, three-way row sums, three-way final sum
    function automatic int acc_width(input int dw, input int cw);
        return dw + cw + 5;
    endfunction

    function automatic logic [31:0] clamp_pix(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< dw) - 64'sd1;
        if (v < 64'sd0) return 32'd0;
        if (v > hi) return hi[31:0];
        return v[31:0];
    endfunction

    function automatic logic clamp_hit(input logic signed [63:0] v, input int dw);
        return (v < 64'sd0) || (v > ((64'sd1 <<< dw) - 64'sd1));
    endfunction

endpackage

// File: rtl/conv3x3_coef_bank.sv
// Double-buffered coefficient store. Writes land in the shadow set; a commit
// is held pending until the next frame start, where the shadow set becomes
// active. The frame-start pixel itself is steered to the shadow values.
module conv3x3_coef_bank
    import conv3x3_kernel_pipe_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic                 isp_clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic signed [CW-1:0] cfg_wdata,
    input  logic                 cfg_commit,
    input  logic                 sof_take,
    output logic [8:0][CW-1:0]   coef_eff,
    output logic                 cfg_pending
);

    logic signed [CW-1:0] shadow_q [NTAPS];
    logic signed [CW-1:0] shadow_d [NTAPS];
    logic signed [CW-1:0] active_q [NTAPS];
    logic signed [CW-1:0] active_d [NTAPS];
    logic                 pending_q, pending_d;
    logic                 commit_req, apply;

    // Shadow write, commit tracking and the frame-start coefficient mux
    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we) begin
            for (int i = 0; i < NTAPS; i++) begin
                if (cfg_addr == 4'(i)) shadow_d[i] = cfg_wdata;
            end
        end
        // A same-cycle write is part of the committed set
        commit_req = pending_q | cfg_commit;
        apply      = sof_take & commit_req;
        pending_d  = commit_req & ~sof_take;
        active_d   = apply ? shadow_d : active_q;
        for (int i = 0; i < NTAPS; i++) begin
            coef_eff[i] = apply ? shadow_d[i] : active_q[i];
        end
    end

    // Coefficient and pending registers; reset restores the default mask
    always_ff @(posedge isp_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= CW'(default_coef(i));
                active_q[i] <= CW'(default_coef(i));
            end
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign cfg_pending = pending_q;

endmodule

// File: rtl/conv3x3_kernel_pipe.sv
// 3x3 convolution kernel: products, row sums, then final sum with optional
// absolute value, rounding shift and clamp. Tag, frame marker and mode ride
// alongside the data; a saturation counter reports the previous frame.
module conv3x3_kernel_pipe
    import conv3x3_kernel_pipe_pkg::*;
#(
    parameter int DW    = 12,
    parameter int TW    = 4,
    parameter int CW    = 5,
    parameter int SHIFT = 3
) (
    input  logic                 isp_clk,
    input  logic                 rst_n,
    input  logic [9*DW-1:0]      pix_in,
    input  logic [TW-1:0]        tag_in,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [1:0]           mode,
    input  logic                 round_en,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic signed [CW-1:0] cfg_wdata,
    input  logic                 cfg_commit,
    output logic [DW+TW-1:0]     dout,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 cfg_pending,
    output logic [15:0]          sat_cnt
);

    localparam int PW      = DW + CW + 1;
    localparam int RW      = PW + 2;
    localparam int ACCW    = acc_width(DW, CW);
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    // Half-LSB rounding (when enabled) followed by arithmetic normalisation
    function automatic logic signed [ACCW-1:0] round_shift(input logic signed [ACCW-1:0] v,
                                                           input logic en);
        logic signed [ACCW-1:0] rc;
        rc          = '0;
        rc[RND_POS] = en && (SHIFT > 0);
        return (v + rc) >>> SHIFT;
    endfunction

    logic [8:0][CW-1:0] coef_eff;

    conv3x3_coef_bank #(.CW(CW)) u_coef_bank (
        .isp_clk     (isp_clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .sof_take    (in_valid & in_sof),
        .coef_eff    (coef_eff),
        .cfg_pending (cfg_pending)
    );

    logic signed [PW-1:0] prod_p1_d [NTAPS];
    logic signed [PW-1:0] prod_p1_q [NTAPS];
    logic [DW-1:0]        ctr_p1_d, ctr_p1_q, ctr_p2_d, ctr_p2_q;
    logic [TW-1:0]        tag_p1_d, tag_p1_q, tag_p2_d, tag_p2_q;
    logic signed [RW-1:0] row_p2_d [3];
    logic signed [RW-1:0] row_p2_q [3];
    logic                 vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
    logic                 sof_p1_d, sof_p1_q, sof_p2_d, sof_p2_q;
    logic                 rnd_p1_d, rnd_p1_q, rnd_p2_d, rnd_p2_q;
    logic [1:0]           mode_p1_d, mode_p1_q, mode_p2_d, mode_p2_q;
    logic signed [ACCW-1:0] sum_s3, sh_s3;
    logic [DW-1:0]        res_s3;
    logic                 hit_s3;
    logic [DW+TW-1:0]     dout_d, dout_q;
    logic                 out_valid_d, out_valid_q, out_sof_d, out_sof_q;
    logic [15:0]          sat_run_d, sat_run_q, sat_cnt_d, sat_cnt_q;

    // ---- stage 1: nine signed products, sideband capture ----
    always_comb begin
        for (int i = 0; i < NTAPS; i++) begin
            prod_p1_d[i] = PW'($signed({1'b0, pix_in[i*DW +: DW]})) * PW'($signed(coef_eff[i]));
        end
        ctr_p1_d  = pix_in[4*DW +: DW];
        tag_p1_d  = tag_in;
        vld_p1_d  = in_valid;
        sof_p1_d  = in_valid & in_sof;
        rnd_p1_d  = round_en;
        mode_p1_d = (mode == MODE_CONV_ALT) ? MODE_CONV : mode;
    end

    // ---- stage 2: row partial sums ----
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            row_p2_d[r] = RW'(prod_p1_q[3*r]) + RW'(prod_p1_q[3*r+1]) + RW'(prod_p1_q[3*r+2]);
        end
        ctr_p2_d  = ctr_p1_q;
        tag_p2_d  = tag_p1_q;
        vld_p2_d  = vld_p1_q;
        sof_p2_d  = sof_p1_q;
        rnd_p2_d  = rnd_p1_q;
        mode_p2_d = mode_p1_q;
    end

    // ---- stage 3: final sum, abs, round/shift, clamp, saturation count ----
    always_comb begin
        sum_s3 = ACCW'(row_p2_q[0]) + ACCW'(row_p2_q[1]) + ACCW'(row_p2_q[2]);
        if (mode_p2_q == MODE_ABS && sum_s3 < 0) sum_s3 = -sum_s3;
        sh_s3 = round_shift(sum_s3, rnd_p2_q);
        if (mode_p2_q == MODE_BYPASS) begin
            res_s3 = ctr_p2_q;
            hit_s3 = 1'b0;
        end else begin
            res_s3 = DW'(clamp_pix(64'(sh_s3), DW));
            hit_s3 = clamp_hit(64'(sh_s3), DW);
        end
        dout_d      = vld_p2_q ? {res_s3, tag_p2_q} : dout_q;
        out_valid_d = vld_p2_q;
        out_sof_d   = sof_p2_q;
        sat_cnt_d   = sat_cnt_q;
        sat_run_d   = sat_run_q;
        if (vld_p2_q) begin
            if (sof_p2_q) begin
                sat_cnt_d = sat_run_q;
                sat_run_d = {15'd0, hit_s3};
            end else if (hit_s3 && sat_run_q != 16'hFFFF) begin
                sat_run_d = sat_run_q + 16'd1;
            end
        end
    end

    // Control, sideband and output registers; reset empties the pipe
    always_ff @(posedge isp_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            sof_p1_q    <= 1'b0;
            sof_p2_q    <= 1'b0;
            rnd_p1_q    <= 1'b0;
            rnd_p2_q    <= 1'b0;
            mode_p1_q   <= MODE_CONV;
            mode_p2_q   <= MODE_CONV;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            sat_run_q   <= '0;
            sat_cnt_q   <= '0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            sof_p1_q    <= sof_p1_d;
            sof_p2_q    <= sof_p2_d;
            rnd_p1_q    <= rnd_p1_d;
            rnd_p2_q    <= rnd_p2_d;
            mode_p1_q   <= mode_p1_d;
            mode_p2_q   <= mode_p2_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            sat_run_q   <= sat_run_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    // Datapath registers; contents are qualified by the valid pipe
    always_ff @(posedge isp_clk) begin
        prod_p1_q <= prod_p1_d;
        ctr_p1_q  <= ctr_p1_d;
        tag_p1_q  <= tag_p1_d;
        row_p2_q  <= row_p2_d;
        ctr_p2_q  <= ctr_p2_d;
        tag_p2_q  <= tag_p2_d;
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_conv3x3_kernel_pipe.sv
// Scoreboard bench for conv3x3_kernel_pipe: directed windows with
// hand-computed results, coefficient commit at frame start, valid gaps and
// a mid-frame asynchronous reset.
module tb_conv3x3_kernel_pipe;

    typedef struct {
        logic [15:0] dout;
        logic        sof;
        int          cyc;
    } exp_t;

    logic              isp_clk = 1'b0;
    logic              rst_n;
    logic [107:0]      pix_in;
    logic [3:0]        tag_in;
    logic              in_valid, in_sof;
    logic [1:0]        mode;
    logic              round_en;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic signed [4:0] cfg_wdata;
    logic              cfg_commit;
    logic [15:0]       dout;
    logic              out_valid, out_sof, cfg_pending;
    logic [15:0]       sat_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    conv3x3_kernel_pipe #(.DW(12), .TW(4), .CW(5), .SHIFT(3)) dut (
        .isp_clk     (isp_clk),
        .rst_n       (rst_n),
        .pix_in      (pix_in),
        .tag_in      (tag_in),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .mode        (mode),
        .round_en    (round_en),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .dout        (dout),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .cfg_pending (cfg_pending),
        .sat_cnt     (sat_cnt)
    );

    always #5 isp_clk = ~isp_clk;
    always @(posedge isp_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    // Window with corners c, edges e, centre m
    function automatic logic [107:0] mk(input logic [11:0] c, input logic [11:0] e,
                                        input logic [11:0] m);
        logic [107:0] w;
        for (int i = 0; i < 9; i++) begin
            if (i == 4)          w[i*12 +: 12] = m;
            else if (i % 2 == 1) w[i*12 +: 12] = e;
            else                 w[i*12 +: 12] = c;
        end
        return w;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge isp_clk);
            #1;
        end
    endtask

    task automatic send(input logic [107:0] w, input logic [3:0] tag, input logic sof,
                        input logic [1:0] md, input logic rnd, input logic [11:0] exp_data);
        exp_t e;
        pix_in   = w;
        tag_in   = tag;
        in_valid = 1'b1;
        in_sof   = sof;
        mode     = md;
        round_en = rnd;
        e.dout   = {exp_data, tag};
        e.sof    = sof;
        e.cyc    = cyc + 3;
        sb.push_back(e);
        @(posedge isp_clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic signed [4:0] d, input logic cm);
        cfg_we     = 1'b1;
        cfg_addr   = a;
        cfg_wdata  = d;
        cfg_commit = cm;
        @(posedge isp_clk);
        #1;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    // Monitor: every valid output must match the oldest expected entry
    always @(negedge isp_clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got dout=%0h expected none", dout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dout", 32'(dout), 32'(e.dout));
                chk("out_sof", 32'(out_sof), 32'(e.sof));
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    logic [11:0] gap_val [5] = '{12'd16, 12'd40, 12'd200, 12'd1000, 12'd4095};
    logic [11:0] gap_exp [5] = '{12'd18, 12'd45, 12'd225, 12'd1125, 12'd4095};

    initial begin
        rst_n = 1'b0; pix_in = '0; tag_in = '0; in_valid = 1'b0; in_sof = 1'b0;
        mode = 2'b00; round_en = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_wdata = '0; cfg_commit = 1'b0;
        idle(3);
        chk("reset_dout", 32'(dout), 0);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_sof", 32'(out_sof), 0);
        chk("reset_cfg_pending", 32'(cfg_pending), 0);
        chk("reset_sat_cnt", 32'(sat_cnt), 0);
        rst_n = 1'b1;
        idle(2);

        // Frame 1, default coefficients
        send(mk(100, 100, 100), 4'h5, 1'b1, 2'b00, 1'b0, 12'd100);
        send(mk(0, 0, 4095),    4'h6, 1'b0, 2'b00, 1'b0, 12'd2047);
        send(mk(4095, 0, 0),    4'h7, 1'b0, 2'b00, 1'b0, 12'd0);     // clamps low
        send(mk(0, 4095, 4095), 4'h8, 1'b0, 2'b00, 1'b0, 12'd4095);  // clamps high
        send(mk(4095, 0, 0),    4'h9, 1'b0, 2'b10, 1'b0, 12'd2047);  // absolute
        send(mk(4095, 4095, 777), 4'hA, 1'b0, 2'b01, 1'b0, 12'd777); // bypass, no clamp flag
        send(mk(100, 100, 100), 4'hB, 1'b0, 2'b11, 1'b0, 12'd100);
        idle(4);
        send(mk(0, 0, 3), 4'hC, 1'b0, 2'b00, 1'b1, 12'd2);           // (12+4)>>3
        idle(4);
        send(mk(0, 0, 3), 4'hD, 1'b0, 2'b00, 1'b0, 12'd1);           // 12>>3
        idle(5);
        chk("sat_cnt_frame0", 32'(sat_cnt), 0);

        // Frame 2: sat_cnt reports the two clamps of frame 1
        send(mk(8, 8, 8), 4'h1, 1'b1, 2'b00, 1'b0, 12'd8);
        idle(5);
        chk("sat_cnt_frame1", 32'(sat_cnt), 2);
        send(mk(4095, 0, 0), 4'h2, 1'b0, 2'b00, 1'b0, 12'd0);        // one clamp in frame 2

        // New coefficient set: all ones, commit with the last write
        wr(4'd9, -5'sd16, 1'b0);
        for (int i = 0; i < 8; i++) wr(4'(i), 5'sd1, 1'b0);
        wr(4'd8, 5'sd1, 1'b1);
        chk("pending_after_commit", 32'(cfg_pending), 1);
        in_sof = 1'b1;
        idle(1);
        in_sof = 1'b0;
        chk("pending_sof_without_valid", 32'(cfg_pending), 1);
        send(mk(8, 8, 8), 4'h3, 1'b0, 2'b00, 1'b0, 12'd8);           // old set until sof
        chk("pending_before_sof", 32'(cfg_pending), 1);

        // Frame 3: sof pixel already uses the new set, 72>>3 = 9
        send(mk(8, 8, 8), 4'h4, 1'b1, 2'b00, 1'b0, 12'd9);
        chk("pending_cleared_at_sof", 32'(cfg_pending), 0);
        send(mk(8, 8, 8), 4'h5, 1'b0, 2'b00, 1'b0, 12'd9);
        idle(5);
        chk("sat_cnt_frame2", 32'(sat_cnt), 1);

        // Flat windows with random valid gaps (sum = 9v, >>3)
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 5; k++) begin
                send(mk(gap_val[k], gap_val[k], gap_val[k]), 4'(k + 6), 1'b0, 2'b00, 1'b0,
                     gap_exp[k]);
                idle($urandom_range(0, 3));
            end
        end
        idle(5);
        chk("scoreboard_drained_before_reset", sb.size(), 0);

        // Reset with two pixels in flight: they are dropped
        send(mk(50, 50, 50), 4'hE, 1'b0, 2'b00, 1'b0, 12'd56);
        send(mk(50, 50, 50), 4'hF, 1'b0, 2'b00, 1'b0, 12'd56);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midreset_dout", 32'(dout), 0);
        chk("midreset_out_valid", 32'(out_valid), 0);
        chk("midreset_sat_cnt", 32'(sat_cnt), 0);
        chk("midreset_cfg_pending", 32'(cfg_pending), 0);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        chk("post_reset_out_valid", 32'(out_valid), 0);
        chk("post_reset_dout", 32'(dout), 0);

        // Default coefficients restored: flat 100 gives 100 (not 112)
        send(mk(100, 100, 100), 4'h7, 1'b0, 2'b00, 1'b0, 12'd100);
        idle(5);
        chk("post_reset_sat_cnt", 32'(sat_cnt), 0);
        chk("scoreboard_drained_final", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv3x3_kernel_pipe.md
# conv3x3_kernel_pipe

Parametrised 3x3 convolution kernel for the ISP pixel path, replacing the earlier fixed-weight mask. It takes a pre-assembled 3x3 window from the line-buffer stage and applies nine programmable signed coefficients. A rounding shift normalises the sum, which is clamped to the pixel range. It carries a per-pixel tag (Bayer state) and frame marker alongside the data with matched latency. Coefficients are double-buffered so that updates take effect only at a frame boundary.

## Interface
- DW, 12, pixel data width (unsigned)
- TW, 4, tag width (Bayer state), passed through unchanged
- CW, 5, signed coefficient width
- SHIFT, 3, right-shift normalisation (0..8)
- isp_clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pix_in  in  9*DW  window p0..p8 row-major, p0 at [DW-1:0], p4 = centre
- tag_in  in  TW  tag of the centre pixel
- in_valid  in  1  window valid this cycle
- in_sof  in  1  first pixel of frame; qualified by in_valid
- mode  in  2  00 convolve, 01 bypass centre, 10 absolute convolve, 11 same as 00
- round_en  in  1  add 2^(SHIFT-1) before shift (ignored when SHIFT=0)
- cfg_we  in  1  shadow coefficient write
- cfg_addr  in  4  coefficient index 0..8; 9..15 ignored
- cfg_wdata  in  CW  signed coefficient
- cfg_commit  in  1  request shadow-to-active copy at next frame start
- dout  out  DW+TW  {data, tag}
- out_valid  out  1  dout valid
- out_sof  out  1  frame marker aligned with dout
- cfg_pending  out  1  commit requested, not yet applied
- sat_cnt  out  16  clamped-pixel count of the previous completed frame

## Operation
- Reset values:
  - Active and shadow coefficients: corners (0, 2, 6, 8) = -1; edges (1, 3, 5, 7) = +2; centre (4) = +4.
  - All outputs 0; internal valid pipe cleared.
- Mode is sampled with each pixel in stage 1 and travels with it.
- Stage 1: nine products p_i*c_i, where p_i is zero-extended and signed; product width DW+CW+1.
- Stage 2: three row partial sums.
- Stage 3: final sum S, width ACCW = DW+CW+5, then:
  - Mode 10: take |S|.
  - If round_en, add the round constant.
  - Arithmetic shift right by SHIFT.
  - Clamp to [0, 2^DW-1].
- Mode 01: data = p4, delayed through the same three stages; the clamp flag is never set.
- Tag, sof and mode are carried through 3 register stages, matched to the data.
- Coefficients:
  - cfg_we writes shadow[cfg_addr] on the same edge.
  - cfg_commit sets pending. pending clears and active <= shadow on the edge where in_valid & in_sof is sampled.
  - The sof pixel itself uses the shadow values (stage-1 mux), so the whole new frame uses the new set.
  - cfg_we and cfg_commit in the same cycle: the write is included in the commit.
  - Writes while pending update the shadow; the latest shadow is copied at sof.
  - cfg_commit in the same cycle as in_valid & in_sof applies immediately.
- Saturation counter:
  - The running counter increments on each out_valid pixel whose result was clamped (low or high); it sticks at 0xFFFF.
  - On out_valid & out_sof: sat_cnt <= running count of the prior pixels; the running counter restarts at 0 or 1, depending on whether the sof pixel itself clamped.

## Timing
- Latency 3 cycles, in_valid -> out_valid. Throughput 1 pixel/cycle.
- No backpressure.
- Bubbles propagate as out_valid = 0. dout holds its last value when not valid.
- in_sof without in_valid is ignored.
- An asynchronous reset mid-frame drops in-flight pixels and restores the default coefficients; the first output after reset is produced 3 cycles after the next in_valid.

## Structure
- Shared ISP package:
  - mode encodings
  - default coefficient constants
  - ACCW derivation function
  - clamp helper function
- One sub-module, conv3x3_coef_bank: shadow/active registers, pending flag, commit logic; outputs the nine effective coefficients, with the stage-1 mux included.
- Top level: 3-stage datapath, sideband pipe, saturation counter.

## Test plan
- Flat input, all pixels 100, default coefficients, SHIFT=3, round_en=0. Sum = 4*100 + 8*100 - 4*100 = 800, so dout data = 100; tag preserved; out_valid exactly 3 cycles after in_valid.
- Centre 4095, others 0. Sum 16380 >> 3 = 2047. Then corners 4095, others 0: result clamps to 0 and sat_cnt counts it.
- Edges 4095, centre 4095: the >>3 result exceeds 4095 and clamps to 4095. Mode 10 with corners 4095, others 0 gives |−16380| >> 3 = 2047.
- Rounding: SHIFT=3, round_en=1, sum 12 -> 2; round_en=0 -> 1.
- Write all coefficients = 1 plus cfg_commit mid-frame:
  - Output is unchanged until the next sof.
  - cfg_pending = 1, then drops on the sof edge.
  - The sof pixel uses the new set: flat 8 input -> 72 >> 3 = 9.
- Random valid gaps, then rst_n asserted mid-frame:
  - Outputs stay in order with no lost or duplicated pixels before the reset.
  - After reset: outputs 0, coefficients at default, sat_cnt = 0.
